// File: rtl/r2sdf_ctrl.sv
// r2sdf_ctrl -- sequencing controller for a radix-2 single-delay-feedback FFT
// pipeline of 2^N points. Owns the pipeline advance enable, per-stage
// butterfly/bypass selects and twiddle addresses, frames the input stream,
// drains the pipeline with zero padding after the last frame and tags the
// output bins.
// Optional feature: define R2SDF_CTRL_BITREV_EN to report out_idx as the
// natural frequency bin (bit-reversed output counter) instead of arrival order.
`timescale 1ns/1ps

module r2sdf_ctrl #(
  parameter int N = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic               stage_en,
  output logic               zero_in,
  output logic [N-1:0]       bf_sel,
  output logic [N*(N-1)-1:0] tw_addr,
  output logic               out_valid,
  output logic [N-1:0]       out_idx,
  output logic               out_last,
  output logic               frame_err
);

  localparam int          FFT_LEN = 1 << N;
  localparam int          LAT     = FFT_LEN - 1 + N;
  localparam logic [15:0] LAT16   = 16'(LAT);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t       state, state_nxt;
  logic [15:0]  m_cnt;      // master advance counter
  logic [15:0]  o_cnt;      // output bin counter
  logic [15:0]  q_cnt;      // accepted sample counter
  logic [15:0]  total;      // samples incl. zero pad, fixed when in_last is taken
  logic [15:0]  drain_cnt;  // remaining DRAIN cycles minus one
  logic [15:0]  q_nxt;
  logic [N-1:0] pad;
  logic         accept, last_acc, drain_done, in_range;

  // Offset of stage s: sum over earlier stages of (delay + 1 register).
  function automatic int stage_off(input int s);
    int acc;
    acc = 0;
    for (int j = 1; j < s; j++) acc += (1 << (N - j)) + 1;
    return acc;
  endfunction

  assign accept     = in_valid & in_ready;
  assign last_acc   = accept & in_last;
  assign q_nxt      = q_cnt + 16'd1;
  // Zeros needed to complete the current frame once the last sample is in.
  assign pad        = '0 - q_nxt[N-1:0];
  assign drain_done = (state == DRAIN) && (drain_cnt == 16'd0);
  assign in_range   = (state != DRAIN) || (o_cnt < total);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers are written with non-blocking assignments so every
    // flop samples the pre-edge values of the others, independent of order.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch forms.
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)     state_nxt = in_last ? DRAIN : RUN;
      RUN:     if (last_acc)   state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // FSM outputs: handshake, advance enable, zero feed and output tagging.
  always_comb begin
    in_ready  = (state != DRAIN);
    zero_in   = (state == DRAIN);
    stage_en  = (in_valid & in_ready) | zero_in;
    out_valid = stage_en & (m_cnt >= LAT16) & in_range;
    out_last  = out_valid & (o_cnt[N-1:0] == {N{1'b1}});
  end

  // Counters, frame bookkeeping and the sticky framing error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt     <= '0;
      o_cnt     <= '0;
      q_cnt     <= '0;
      total     <= '0;
      drain_cnt <= '0;
      frame_err <= 1'b0;
    end else if (drain_done) begin
      m_cnt <= '0;
      o_cnt <= '0;
      q_cnt <= '0;
      total <= '0;
    end else begin
      if (stage_en)  m_cnt <= m_cnt + 16'd1;
      if (out_valid) o_cnt <= o_cnt + 16'd1;
      if (accept)    q_cnt <= q_nxt;
      if (last_acc) begin
        total     <= q_nxt + 16'(pad);
        drain_cnt <= 16'(pad) + LAT16 - 16'd1;
        if (q_nxt[N-1:0] != '0) frame_err <= 1'b1;
      end else if (state == DRAIN) begin
        drain_cnt <= drain_cnt - 16'd1;
      end
    end
  end

`ifdef R2SDF_CTRL_BITREV_EN
  // Natural frequency bin: bit-reverse of the arrival position in the frame.
  always_comb begin
    out_idx = '0;
    for (int i = 0; i < N; i++) out_idx[i] = o_cnt[N-1-i];
  end
`else
  // Arrival order; reordering is left to downstream logic.
  always_comb begin
    out_idx = o_cnt[N-1:0];
  end
`endif

  // Per-stage decode. Only bits [N-s:0] of the local count matter for stage s:
  // bit N-s selects the mode and the bits below it index the twiddle table.
  // Selects are held at zero when the pipeline does not advance.
  for (genvar s = 1; s <= N; s++) begin : g_stage
    localparam int OFF = stage_off(s);
    logic [N-s:0] c_loc;
    logic [N-2:0] tw;

    assign c_loc = m_cnt[N-s:0] - (N-s+1)'(OFF);

    if (s < N) begin : g_tw
      assign tw = (N-1)'(c_loc[N-s-1:0]) << (s - 1);
    end else begin : g_tw_zero
      assign tw = '0;
    end

    assign bf_sel[s-1]                  = stage_en & c_loc[N-s];
    assign tw_addr[(s-1)*(N-1) +: N-1] = (stage_en & ~c_loc[N-s]) ? tw : '0;
  end

endmodule
